// File: rtl/guess_entry.sv
// rtl/guess_entry.sv - debounced 10-key four-digit guess entry with ready/valid handoff
`timescale 1ns/1ps
module guess_entry #(
  parameter int DB_CYCLES = 20000,
  parameter int DB_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  key,
  input  logic        clear,
  input  logic        guess_ready,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic [2:0]  digit_count,
  output logic        dup_err
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {REL, PCNT, HELD, RCNT} db_state_t;
  typedef enum logic {ENTRY, PRESENT} en_state_t;

  logic [9:0]      key_meta, key_sync;
  logic            single;
  logic [3:0]      enc;
  logic [3:0]      key_ones;

  db_state_t       db_state, db_next;
  logic [DB_W-1:0] cnt, cnt_next;
  logic [3:0]      db_code, db_code_next;
  logic            press, press_next;

  en_state_t       en_state, en_next;
  logic [15:0]     guess_next;
  logic [2:0]      count_next;
  logic            valid_next, dup_next;
  logic            fresh, fresh_next;
  logic            is_dup;

  // two-flop synchronizer on every raw key level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // count high keys and encode the (single) active one
  always_comb begin
    key_ones = 4'd0;
    enc      = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_sync[i]) begin
        key_ones = key_ones + 4'd1;
        enc      = 4'(i);
      end
    end
    single = (key_ones == 4'd1);
  end

  // debounce state, stability counter, captured digit and press pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_state <= REL;
      cnt      <= '0;
      db_code  <= 4'd0;
      press    <= 1'b0;
    end else begin
      db_state <= db_next;
      cnt      <= cnt_next;
      db_code  <= db_code_next;
      press    <= press_next;
    end
  end

  // debounce next state: a press needs DB_CYCLES stable single-key cycles,
  // re-arming needs DB_CYCLES stable all-released cycles
  always_comb begin
    db_next      = db_state;
    cnt_next     = cnt;
    db_code_next = db_code;
    press_next   = 1'b0;
    case (db_state)
      REL: begin
        cnt_next = '0;
        if (single) begin
          db_next      = PCNT;
          cnt_next     = DB_W'(1);
          db_code_next = enc;
        end
      end
      PCNT: begin
        if (!single || enc != db_code) begin
          db_next  = REL;
          cnt_next = '0;
        end else if (cnt == DB_LAST) begin
          db_next    = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + DB_W'(1);
        end
      end
      HELD: begin
        cnt_next = '0;
        if (key_sync == 10'd0) begin
          db_next  = RCNT;
          cnt_next = DB_W'(1);
        end
      end
      RCNT: begin
        if (key_sync != 10'd0) begin
          db_next  = HELD;
          cnt_next = '0;
        end else if (cnt == DB_LAST) begin
          db_next  = REL;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + DB_W'(1);
        end
      end
      default: begin
        db_next  = REL;
        cnt_next = '0;
      end
    endcase
  end

  // is the pressed digit already among the stored ones
  always_comb begin
    is_dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < digit_count && guess[4*i +: 4] == db_code) is_dup = 1'b1;
    end
  end

  // entry state and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_state    <= ENTRY;
      guess       <= 16'h0000;
      digit_count <= 3'd0;
      guess_valid <= 1'b0;
      dup_err     <= 1'b0;
      fresh       <= 1'b0;
    end else begin
      en_state    <= en_next;
      guess       <= guess_next;
      digit_count <= count_next;
      guess_valid <= valid_next;
      dup_err     <= dup_next;
      fresh       <= fresh_next;
    end
  end

  // entry next state: clear beats press; after a transfer the old guess
  // stays visible until the first new digit replaces it outright
  always_comb begin
    en_next    = en_state;
    guess_next = guess;
    count_next = digit_count;
    valid_next = guess_valid;
    dup_next   = 1'b0;
    fresh_next = fresh;
    case (en_state)
      ENTRY: begin
        if (clear) begin
          guess_next = 16'h0000;
          count_next = 3'd0;
          fresh_next = 1'b0;
        end else if (press) begin
          if (is_dup) begin
            dup_next = 1'b1;
          end else begin
            guess_next = fresh ? {12'h000, db_code} : {guess[11:0], db_code};
            count_next = digit_count + 3'd1;
            fresh_next = 1'b0;
            if (digit_count == 3'd3) begin
              en_next    = PRESENT;
              valid_next = 1'b1;
            end
          end
        end
      end
      PRESENT: begin
        if (guess_ready) begin
          en_next    = ENTRY;
          valid_next = 1'b0;
          count_next = 3'd0;
          fresh_next = 1'b1;
        end
      end
      default: en_next = ENTRY;
    endcase
  end

endmodule

// File: tb/tb_guess_entry.sv
// tb/tb_guess_entry.sv - directed and random checks of guess_entry against a behavioural model
`timescale 1ns/1ps
module tb_guess_entry;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  key;
  logic        clear;
  logic        guess_ready;
  logic [15:0] guess;
  logic        guess_valid;
  logic [2:0]  digit_count;
  logic        dup_err;

  int total = 0;
  int bad = 0;
  int dup_seen = 0;

  // model state
  logic [9:0] m_s1, m_s2, m_run_val;
  int         m_run_len;
  bit         m_armed, m_press, m_present, m_fresh, m_dup;
  int         m_pdigit;
  int         m_guess;
  int         m_digits[$];

  guess_entry #(.DB_CYCLES(DB), .DB_W(16)) dut (
    .clk(clk), .rst(rst), .key(key), .clear(clear), .guess_ready(guess_ready),
    .guess(guess), .guess_valid(guess_valid), .digit_count(digit_count), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_run_val = '0; m_run_len = 0;
    m_armed = 1; m_press = 0; m_present = 0; m_fresh = 0; m_dup = 0;
    m_pdigit = 0; m_guess = 0; m_digits.delete();
  endtask

  // one clock edge of the reference behaviour, using the inputs applied before it
  task automatic model_edge();
    bit new_press, new_dup, found;
    if (!rst) begin
      model_reset();
      return;
    end
    new_dup = 0;
    if (m_present) begin
      if (guess_ready) begin
        m_present = 0; m_digits.delete(); m_fresh = 1;
      end
    end else if (clear) begin
      m_digits.delete(); m_guess = 0; m_fresh = 0;
    end else if (m_press) begin
      found = 0;
      foreach (m_digits[i]) if (m_digits[i] == m_pdigit) found = 1;
      if (found) new_dup = 1;
      else begin
        m_guess = m_fresh ? m_pdigit : (((m_guess << 4) | m_pdigit) & 'hffff);
        m_fresh = 0;
        m_digits.push_back(m_pdigit);
        if (m_digits.size() == 4) m_present = 1;
      end
    end
    m_dup = new_dup;
    new_press = 0;
    if (m_s2 == m_run_val) m_run_len++;
    else begin
      m_run_val = m_s2; m_run_len = 1;
    end
    if (m_armed && $countones(m_s2) == 1 && m_run_len == DB) begin
      new_press = 1; m_pdigit = $clog2(m_s2); m_armed = 0;
    end else if (!m_armed && m_s2 == 10'd0 && m_run_len == DB) begin
      m_armed = 1;
    end
    m_press = new_press;
    m_s2 = m_s1;
    m_s1 = key;
  endtask

  task automatic check_all();
    chk("guess", 32'(guess), 32'(m_guess));
    chk("guess_valid", 32'(guess_valid), 32'(m_present));
    chk("digit_count", 32'(digit_count), 32'(m_digits.size()));
    chk("dup_err", 32'(dup_err), 32'(m_dup));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    if (dup_err === 1'b1) dup_seen++;
  endtask

  task automatic hold(input logic [9:0] p, input int n);
    key = p;
    repeat (n) step();
  endtask

  task automatic enter(input int d);
    hold(10'(1 << d), 10);
    hold(10'd0, 10);
  endtask

  initial begin
    logic [9:0] p;
    int n;
    rst = 1'b0; key = '0; clear = 1'b0; guess_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_guess", 32'(guess), 32'h0);
    chk("rst_valid", 32'(guess_valid), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_dup", 32'(dup_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // four digits with consumer stalled
    for (int d = 1; d <= 4; d++) enter(d);
    repeat (50) step();
    chk("r30_guess", 32'(guess), 32'h1234);
    chk("r30_valid", 32'(guess_valid), 32'h1);
    chk("r30_count", 32'(digit_count), 32'h4);

    guess_ready = 1'b1; step(); guess_ready = 1'b0;
    chk("xfer_valid", 32'(guess_valid), 32'h0);
    chk("xfer_count", 32'(digit_count), 32'h0);
    chk("xfer_guess_kept", 32'(guess), 32'h1234);

    // duplicate rejection
    enter(5);
    dup_seen = 0;
    enter(5);
    chk("r31_dup_pulses", 32'(dup_seen), 32'h1);
    chk("r31_count", 32'(digit_count), 32'h1);
    chk("r31_guess", 32'(guess), 32'h0005);
    enter(7);
    chk("r31_guess2", 32'(guess), 32'h0057);
    chk("r31_count2", 32'(digit_count), 32'h2);

    // bounce too short, then two keys at once
    clear = 1'b1; step(); clear = 1'b0;
    dup_seen = 0;
    hold(10'(1 << 8), 2); hold(10'd0, 10);
    hold(10'h048, 10); hold(10'd0, 10);
    chk("r32_count", 32'(digit_count), 32'h0);
    chk("r32_dup", 32'(dup_seen), 32'h0);

    // press ignored while presenting, then transfer
    enter(9); enter(0); enter(1); enter(2);
    chk("r33_guess", 32'(guess), 32'h9012);
    chk("r33_valid", 32'(guess_valid), 32'h1);
    dup_seen = 0;
    enter(4);
    chk("r33_ignored", 32'(guess), 32'h9012);
    chk("r33_nodup", 32'(dup_seen), 32'h0);
    guess_ready = 1'b1; step(); guess_ready = 1'b0;
    chk("r33_valid_fall", 32'(guess_valid), 32'h0);
    chk("r33_count0", 32'(digit_count), 32'h0);
    chk("r33_guess_kept", 32'(guess), 32'h9012);
    enter(7);
    chk("r33_guess7", 32'(guess), 32'h0007);

    // clear in the same cycle as a completing press
    enter(2);
    chk("r34_count2", 32'(digit_count), 32'h2);
    key = 10'(1 << 3);
    for (int i = 0; i < 20 && !m_press; i++) step();
    chk("r34_press_timeout", 32'(m_press), 32'h1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("r34_guess", 32'(guess), 32'h0);
    chk("r34_count", 32'(digit_count), 32'h0);
    chk("r34_dup", 32'(dup_err), 32'h0);
    hold(10'd0, 10);

    // asynchronous reset mid-count
    enter(1); enter(2);
    chk("r34_pre_guess", 32'(guess), 32'h0012);
    key = 10'(1 << 5);
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_guess", 32'(guess), 32'h0);
    chk("arst_valid", 32'(guess_valid), 32'h0);
    chk("arst_count", 32'(digit_count), 32'h0);
    chk("arst_dup", 32'(dup_err), 32'h0);
    model_reset();
    repeat (3) step();
    rst = 1'b1;
    hold(10'(1 << 5), 3);
    chk("post_rst_early", 32'(digit_count), 32'h0);
    hold(10'(1 << 5), 7);
    chk("post_rst_count", 32'(digit_count), 32'h1);
    chk("post_rst_guess", 32'(guess), 32'h0005);
    hold(10'd0, 10);

    // random key traffic; every non-idle pattern returns to idle
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 9) < 7) p = 10'(1 << $urandom_range(0, 9));
      else begin
        p = 10'($urandom);
        while ($countones(p) < 2) p = 10'($urandom);
      end
      n = $urandom_range(1, 8);
      key = p;
      for (int c = 0; c < n; c++) begin
        clear = ($urandom_range(0, 29) == 0);
        guess_ready = ($urandom_range(0, 3) == 0);
        step();
      end
      n = $urandom_range(1, 8);
      key = 10'd0;
      for (int c = 0; c < n; c++) begin
        clear = ($urandom_range(0, 29) == 0);
        guess_ready = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    clear = 1'b0; guess_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
